// File: rtl/apb_requester.sv
// Single-requester APB bridge: decodes a one-cycle front-bus request into a
// one-hot PSEL, runs SETUP/ACCESS, and returns a registered completion pulse.
module apb_requester #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_COMP   = 4,
  parameter logic [15:0] BASE_HI    = 16'h1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_COMP-1:0]   PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [NUM_COMP-1:0]     psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

  logic [3:0]              slot;
  logic                    mapped;
  logic [NUM_COMP-1:0]     sel_vec;
  logic                    timed_out;

  assign slot      = addr[15:12];
  assign mapped    = (addr[31:16] == BASE_HI) && ({1'b0, slot} < 5'(NUM_COMP));
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      sel_vec[i] = (slot == 4'(i));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer && mapped) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data phase registers hold across idle so the bus does not toggle.
  always_comb begin
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (mapped) begin
            paddr_d   = addr[ADDR_WIDTH-1:0];
            pwrite_d  = write;
            pwdata_d  = wdata;
            psel_d    = sel_vec;
            penable_d = 1'b0;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? '0 : PRDATA;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (timed_out) begin
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign PADDR   = paddr_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios plus randomized transactions,
// each checked against a latency/response model derived from the bus rules.
module tb_apb_requester;

  localparam int NUM_COMP = 4;
  localparam int TIMEOUT  = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] PADDR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rdata = '0;

  apb_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_COMP(NUM_COMP),
    .BASE_HI(16'h1000), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Reference rules: mapping, and cycles from request to completion.
  function automatic bit is_mapped(logic [31:0] a);
    return (a[31:16] == 16'h1000) && (int'(a[15:12]) < NUM_COMP);
  endfunction

  function automatic int latency(bit m, int waits);
    if (!m) return 1;
    if (waits < TIMEOUT) return 3 + waits;
    return 2 + TIMEOUT;
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Issues one request and checks every cycle up to its completion.
  // waits: ACCESS cycles the completer holds PREADY low; poke: pulse a
  // stray transfer during ACCESS.
  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input bit poke);
    bit          m;
    bit          to;
    bit          in_apb;
    int          lat;
    int          acc;
    logic [3:0]  exp_psel;
    logic [31:0] exp_rd;
    m        = is_mapped(a);
    to       = m && (waits >= TIMEOUT);
    lat      = latency(m, waits);
    exp_psel = m ? (4'b0001 << a[15:12]) : 4'b0000;
    exp_rd   = (m && !to && !wr) ? prd : 32'h0;
    acc      = 0;
    transfer = 1'b1; write = wr; addr = a; wdata = wd;
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) transfer = 1'b0;
      if (poke && k == 3) begin transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000; end
      if (poke && k == 4) transfer = 1'b0;
      in_apb = m && (k < lat);
      checks++;
      if (PSEL !== (in_apb ? exp_psel : 4'b0000)) begin
        failures++;
        $display("FAIL psel a=%h k=%0d got=%b exp=%b", a, k, PSEL, in_apb ? exp_psel : 4'b0000);
      end
      checks++;
      if (PENABLE !== (in_apb && k >= 2)) begin
        failures++;
        $display("FAIL penable a=%h k=%0d got=%b exp=%b", a, k, PENABLE, in_apb && k >= 2);
      end
      checks++;
      if (ready !== (k == lat)) begin
        failures++;
        $display("FAIL ready a=%h k=%0d got=%b exp=%b", a, k, ready, k == lat);
      end
      checks++;
      if (err !== ((k == lat) && (!m || to))) begin
        failures++;
        $display("FAIL err a=%h k=%0d got=%b exp=%b", a, k, err, (k == lat) && (!m || to));
      end
      if (in_apb) begin
        checks++;
        if (PADDR !== a || PWRITE !== wr || PWDATA !== wd) begin
          failures++;
          $display("FAIL apb_addr_phase k=%0d got=%h/%b/%h exp=%h/%b/%h",
                   k, PADDR, PWRITE, PWDATA, a, wr, wd);
        end
      end
      if (k == lat) begin
        checks++;
        if (rdata !== exp_rd) begin
          failures++;
          $display("FAIL rdata a=%h got=%h exp=%h", a, rdata, exp_rd);
        end
        last_rdata = exp_rd;
      end
      // Completer: responds only to PSEL&PENABLE, garbage elsewhere.
      if (PSEL != 4'b0000 && PENABLE) begin
        PREADY = (acc == waits);
        PRDATA = (acc == waits) ? prd : $urandom;
        acc++;
      end else begin
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
    end
    PREADY = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    step(); step();
    checks++;
    if (PSEL !== 4'b0 || PENABLE !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got psel=%b en=%b rdy=%b err=%b exp=0", PSEL, PENABLE, ready, err);
    end
    checks++;
    if (PADDR !== 32'h0 || PWRITE !== 1'b0 || PWDATA !== 32'h0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got %h/%b/%h/%h exp=0", PADDR, PWRITE, PWDATA, rdata);
    end
    PRESETn = 1'b1;
    step();
  endtask

  task automatic test_write();
    do_xfer(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    checks++;
    if (PSEL !== 4'b0000 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL write_done got psel=%b rdata=%h exp 0/0", PSEL, rdata);
    end
    step();
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 32'h1000_0010, 32'h0, 3, 32'h1234_5678, 1'b0);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_wait_rdata got=%h exp=12345678", rdata);
    end
    step();
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_hold got rdy=%b rdata=%h exp 0/12345678", ready, rdata);
    end
  endtask

  task automatic test_unmapped();
    do_xfer(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
    step();
    do_xfer(1'b0, 32'h1000_7000, 32'h0, 0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h1000_3008, 32'h5, TIMEOUT, 32'hAAAA_5555, 1'b0);
    do_xfer(1'b0, 32'h1000_300C, 32'h6, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
    do_xfer(1'b1, 32'h1000_1000, 32'h7, 1, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 32'h1000_1040, 32'h1111_1111, 0, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h1000_3044, 32'h0, 0, 32'h3333_3333, 1'b0);
    do_xfer(1'b0, 32'h1000_2000, 32'h0, 3, 32'h4444_4444, 1'b1);
    step();
    checks++;
    if (ready !== 1'b0 || PSEL !== 4'b0000) begin
      failures++;
      $display("FAIL ignored_pulse got rdy=%b psel=%b exp 0/0000", ready, PSEL);
    end
    step();
  endtask

  task automatic test_reset_mid();
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
    step();
    transfer = 1'b0;
    step();
    checks++;
    if (PENABLE !== 1'b1) begin
      failures++;
      $display("FAIL mid_access_entry got en=%b exp=1", PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (PSEL !== 4'b0 || PENABLE !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got psel=%b en=%b rdy=%b err=%b exp=0", PSEL, PENABLE, ready, err);
    end
    step();
    PRESETn = 1'b1;
    step();
    last_rdata = '0;
    do_xfer(1'b0, 32'h1000_2020, 32'h0, 0, 32'h7777_0001, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [15:0] hi;
    int          r;
    int          waits;
    int          gap;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 7) begin
        hi = 16'($urandom);
        if (hi == 16'h1000) hi = 16'h1001;
        a = {hi, 16'($urandom)};
      end else if (r == 8) begin
        a = {16'h1000, 4'($urandom_range(NUM_COMP, 15)), 12'($urandom)};
      end else begin
        a = {16'h1000, 4'($urandom_range(0, NUM_COMP - 1)), 12'($urandom)};
      end
      r = $urandom_range(0, 9);
      waits = (r == 9) ? TIMEOUT : (r == 8) ? TIMEOUT - 1 : $urandom_range(0, 4);
      do_xfer(1'($urandom_range(0, 1)), a, $urandom, waits, $urandom,
              (waits >= 2) && ($urandom_range(0, 1) == 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (ready !== 1'b0 || PSEL !== 4'b0 || rdata !== last_rdata) begin
          failures++;
          $display("FAIL idle_gap got rdy=%b psel=%b rdata=%h exp 0/0000/%h",
                   ready, PSEL, rdata, last_rdata);
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Bridges the CPU-side front bus (transfer/write/addr/wdata → rdata/ready) onto the shared APB bus as its single requester.
- Decodes the front address into a one-hot PSEL across NUM_COMP completers.
- Runs the APB SETUP/ACCESS sequence and returns read data and completion.
- Terminates unmapped accesses and stalled completers with an error completion so the CPU never hangs.

Parameters:
- ADDR_WIDTH, 32, PADDR width; PADDR = latched front addr[ADDR_WIDTH-1:0].
- DATA_WIDTH, 32, PWDATA/PRDATA/wdata/rdata width.
- NUM_COMP, 4, number of completers and PSEL width (1..16).
- BASE_HI, 16'h1000, required value of addr[31:16] for a mapped access.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (>=2).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- transfer  in  1  one-cycle request strobe; write/addr/wdata valid in the same cycle.
- write  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; 1 = unmapped or timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NUM_COMP  one-hot completer select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  completer ready, sampled only in ACCESS.
- PRDATA  in  DATA_WIDTH  completer read data.

Behaviour:
- Reset (async on PRESETn=0, from any state including mid-transfer): state IDLE; all outputs 0; timeout counter 0.
- All outputs are registered; nothing combinational from input to output.

Address decode:
- slot = addr[15:12].
- The access is mapped iff addr[31:16]==BASE_HI and slot<NUM_COMP.
- PSEL[slot] is the only bit set during SETUP and ACCESS; PSEL=0 at all other times.

FSM states: IDLE, SETUP, ACCESS.
- IDLE with transfer=1 and mapped:
  - latch PADDR, PWRITE, PWDATA and the slot;
  - next state SETUP (PSEL set, PENABLE=0).
- IDLE with transfer=1 and unmapped:
  - no APB activity;
  - next cycle ready=1, err=1, rdata=0; remain IDLE.
- SETUP → ACCESS unconditionally: PENABLE=1, PSEL held, timeout counter cleared.
- ACCESS with PREADY=1:
  - capture PRDATA into rdata on reads; rdata=0 on writes;
  - next cycle ready=1, err=0, PSEL=0, PENABLE=0, state IDLE.
- ACCESS with PREADY=0:
  - counter increments;
  - when the counter reaches TIMEOUT-1 and PREADY is still 0, abort: next cycle PSEL=0, PENABLE=0, ready=1, err=1, rdata=0, state IDLE.
  - PREADY=1 on that same final cycle counts as success, not timeout.
- PADDR, PWRITE and PWDATA hold their last values after a transfer until the next SETUP (no gratuitous toggling).
- ready and err are high for exactly one cycle; rdata holds its value until the next completion.
- transfer while in SETUP or ACCESS is ignored (not queued).
- transfer in the cycle ready=1 is accepted, because the state is already IDLE. This gives back-to-back throughput of one transfer per 3 cycles with zero wait states.
- Minimum latency: transfer at cycle N → SETUP N+1 → ACCESS N+2 → ready at N+3. Each completer wait state adds 1 cycle.

Test Plan:
- Reset, then write addr=0x1000_2004, wdata=0xDEADBEEF, PREADY tied 1 → PSEL=4'b0100 at N+1 (PENABLE=0) and N+2 (PENABLE=1); PADDR=0x1000_2004; PWRITE=1; ready=1, err=0 at N+3.
- Read addr=0x1000_0010, completer holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x1234_5678 → ready at N+6, rdata=0x1234_5678, PSEL=0 the same cycle.
- Read addr=0x2000_0000 (bad BASE_HI) and addr=0x1000_7000 (slot 7 ≥ NUM_COMP) → PSEL stays 0; ready=1, err=1, rdata=0 at N+1.
- Completer never asserts PREADY, TIMEOUT=16 → ACCESS lasts 16 cycles; then ready=1, err=1, PSEL=0, PENABLE=0. A following mapped transfer completes normally.
- Back-to-back: a second transfer pulsed in the ready cycle of the first (slot 1, then slot 3) → SETUP with PSEL=4'b1000 the next cycle. A transfer pulsed during ACCESS is ignored (no extra ready).
- PRESETn dropped during ACCESS → PSEL, PENABLE, ready, err go to 0 immediately (asynchronously). After release, the next transfer starts a clean SETUP.
